// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
//
// Holds the controller state enum, the default memory_block address width,
// the access counter width and the access-kind encodings used on the
// req_write / req_byte inputs.
package lsu_pkg;

    localparam int LSU_ADDR_W = 18;

    // Counter covers ACCESS_CYCLES-1 for ACCESS_CYCLES up to 15.
    localparam int LSU_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Access-kind encodings of req_write and req_byte.
    localparam logic KIND_LOAD  = 1'b0;
    localparam logic KIND_STORE = 1'b1;
    localparam logic KIND_BYTE  = 1'b1;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - word/byte and sign/zero extension of memory read data
//
// Purpose: shapes the raw memory_block read word into the load result.
//   Word loads pass the data through; byte loads keep bits 7:0 and fill the
//   upper 24 bits with bit 7 (signed) or zero (unsigned). Bits 31:8 of the
//   raw data are ignored for byte loads.
// Ports:
//   raw_data  in  32  memory_block read_data
//   byte_op   in   1  1 = byte access
//   signed_op in   1  1 = sign-extend a byte load
//   ext_data  out 32  extended load result
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic        byte_op,
    input  logic        signed_op,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = raw_data;
        if (byte_op == KIND_BYTE) begin
            ext_data = {{24{signed_op & raw_data[7]}}, raw_data[7:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store front end for memory_block
//
// Purpose: accepts one load/store request at a time, drives memory_block for
//   ACCESS_CYCLES cycles, captures and extends load data, and returns a
//   one-cycle response. Out-of-range addresses are rejected without any
//   memory strobe.
// Optional feature: define LSU_ALIGN_CHECK_EN to also reject word accesses
//   whose address is not 4-byte aligned.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_write/req_byte/req_signed access kind
//   req_addr/req_wdata           byte address and store data
//   resp_valid/resp_rdata/resp_error  one-cycle completion
//   mem_address/mem_write_data/mem_read/mem_write/mem_byte_operations
//                                drive memory_block
//   mem_read_data                memory_block read data (combinational)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W        = LSU_ADDR_W,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte_operations,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e           state_q, state_d;
    logic [LSU_CNT_W-1:0] cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic                 byte_q, byte_d;
    logic                 signed_q, signed_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic [31:0]          result_q, result_d;

    logic                 addr_ok;
    logic [31:0]          ext_data;

    load_extend u_load_extend (
        .raw_data  (mem_read_data),
        .byte_op   (byte_q),
        .signed_op (signed_q),
        .ext_data  (ext_data)
    );

    // Acceptance check on the live request; upper address bits beyond the
    // memory window make the access illegal.
    always_comb begin
        addr_ok = (req_addr[31:ADDR_W] == '0);
`ifdef LSU_ALIGN_CHECK_EN
        if ((req_byte != KIND_BYTE) && (req_addr[1:0] != 2'b00)) begin
            addr_ok = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    result_d = '0;
                    if (addr_ok) begin
                        // The memory-facing latches only change for accesses
                        // that really reach memory, so mem_* outputs keep
                        // their last value across rejected requests.
                        write_d  = req_write;
                        byte_d   = req_byte;
                        signed_d = req_signed;
                        addr_d   = req_addr[ADDR_W-1:0];
                        wdata_d  = req_wdata;
                        err_d    = 1'b0;
                        cnt_d    = LSU_CNT_W'(ACCESS_CYCLES - 1);
                        state_d  = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (write_q == KIND_LOAD) begin
                        result_d = ext_data;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset drops them in the same cycle.
    assign req_ready           = (state_q == IDLE);
    assign mem_read            = (state_q == ACCESS) && (write_q == KIND_LOAD);
    assign mem_write           = (state_q == ACCESS) && (write_q == KIND_STORE);
    assign mem_address         = addr_q;
    assign mem_write_data      = wdata_q;
    assign mem_byte_operations = byte_q;

    assign resp_valid = (state_q == RESP);
    assign resp_error = resp_valid & err_q;
    assign resp_rdata = resp_valid ? result_q : '0;

endmodule
